// File: rtl/bus_transfer_ctrl.sv
`timescale 1ns/1ps
// Bus transfer sequencer: turns a one-hot source request into a held mux select
// code, then strobes the latched destination loads for one cycle.
//
// state | meaning
// IDLE  | ready for a request; select parked on IDLE_SEL
// DRIVE | select holds the source code while the hold timer runs down
// LOAD  | select still held; dst_load strobes the latched destinations
// DONE  | done pulse, bus released, one cycle before ready again
module bus_transfer_ctrl #(
  parameter int unsigned HOLD_CYCLES = 1,
  parameter logic [4:0]  IDLE_SEL    = 5'd31
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] src_onehot,
  input  logic [23:0] dst_onehot,
  output logic [4:0]  select,
  output logic [23:0] dst_load,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    LOAD  = 2'd2,
    DONE  = 2'd3
  } stateT;

  stateT       state;
  logic [3:0]  holdCnt;
  logic [23:0] latchedDst;

  logic        srcIsOneHot;
  logic        reqOk;
  logic [4:0]  srcCode;

  // OR of the indices of set bits; only meaningful once the one-hot check passes.
  function automatic logic [4:0] encodeOneHot(input logic [23:0] vec);
    logic [4:0] code;
    code = '0;
    for (int i = 0; i < 24; i++) begin
      if (vec[i]) code = code | 5'(i);
    end
    return code;
  endfunction

  always_comb begin
    srcIsOneHot = (src_onehot != 24'd0) &&
                  ((src_onehot & (src_onehot - 24'd1)) == 24'd0);
    reqOk       = srcIsOneHot && (dst_onehot != 24'd0);
    srcCode     = encodeOneHot(src_onehot);
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      state      <= IDLE;
      holdCnt    <= '0;
      latchedDst <= '0;
      select     <= IDLE_SEL;
      dst_load   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      req_ready  <= 1'b1;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      dst_load <= '0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (reqOk) begin
              // select itself serves as the latched source code
              select     <= srcCode;
              latchedDst <= dst_onehot;
              holdCnt    <= HOLD_LOAD;
              busy       <= 1'b1;
              req_ready  <= 1'b0;
              state      <= DRIVE;
            end else begin
              err <= 1'b1;
            end
          end
        end
        DRIVE: begin
          if (holdCnt == 4'd0) begin
            dst_load <= latchedDst;
            state    <= LOAD;
          end else begin
            holdCnt <= holdCnt - 4'd1;
          end
        end
        LOAD: begin
          select <= IDLE_SEL;
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          select    <= IDLE_SEL;
          busy      <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/bus_transfer_ctrl.md
# bus_transfer_ctrl

Sequencer for the source/destination ends of the datapath's shared 32-bit bus. It accepts one transfer request as a one-hot source vector and a one-hot-or-multi destination vector. It encodes the source into the 5-bit select code consumed by the 32:1 bus multiplexer, holds the bus stable, and pulses the destination load enables for exactly one cycle. Malformed requests are rejected with an error pulse. It sits between the control unit and the bus multiplexer and register load inputs.

## Interface
- HOLD_CYCLES, default 1: cycles select is driven before the load strobe. Legal range 1..15.
- IDLE_SEL, default 5'd31: select code driven when no transfer is active. It falls in the mux default range, so the bus reads 0.

- clock  in  1  rising-edge clock.
- clear  in  1  synchronous, active-low reset, sampled on the rising edge of clock.
- req_valid  in  1  transfer request present.
- req_ready  out  1  block can accept a request this cycle.
- src_onehot  in  24  source select. Bit i selects mux code i:
  - 0-15: R0-R15
  - 16: HI
  - 17: LO
  - 18: Z_high
  - 19: Z_low
  - 20: PC
  - 21: MDR
  - 22: InPort
  - 23: C_sign_extended
- dst_onehot  in  24  destination register load enables, passed through unencoded. Multiple bits are allowed.
- select  out  5  bus mux select code.
- dst_load  out  24  one-cycle load strobes to destination registers.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse when a transfer completes.
- err  out  1  one-cycle pulse when a request is rejected.

## Operation
- All outputs are registered.
- Reset values (clear low at an edge): select=IDLE_SEL, dst_load=0, busy=0, done=0, err=0, req_ready=1, state=IDLE, hold counter=0.
- States:
  - IDLE: req_ready=1, select=IDLE_SEL. The request is accepted at an edge where req_valid=1.
    - If src_onehot has exactly one bit set and dst_onehot≠0: latch the binary encoding of src and latch dst, load the hold counter with HOLD_CYCLES-1, go to DRIVE.
    - Otherwise: err=1 for the next cycle only, stay in IDLE, latch nothing.
  - DRIVE: select=latched code, busy=1, req_ready=0. Decrement the counter each cycle. At counter=0, go to LOAD.
  - LOAD: select still equals the latched code. dst_load=latched dst for exactly this cycle, busy=1. Go to DONE.
  - DONE: done=1, dst_load=0, select=IDLE_SEL, busy=0, req_ready=0. Go to IDLE.
- The encoding is a priority-free one-hot to binary encode. The validity check (popcount==1) guarantees a unique code. Codes 24-31 are never produced except IDLE_SEL.
- req_valid while req_ready=0 is ignored; the request is neither queued nor flagged.
- src and dst are sampled only at acceptance. Changes during DRIVE/LOAD have no effect.
- The same register as both source and destination is legal. The register captures its own value.
- An out-of-range HOLD_CYCLES is a configuration error, with no runtime check. Synthesis uses a 4-bit counter.

## Timing
- Acceptance edge = cycle 0.
- select shows the latched code in cycles 1..HOLD_CYCLES.
- dst_load is high in cycle HOLD_CYCLES+1. select is unchanged in that cycle, so destinations capture a bus value that has been stable for HOLD_CYCLES+1 cycles.
- done is high in cycle HOLD_CYCLES+2, with select=IDLE_SEL.
- req_ready returns to 1 in cycle HOLD_CYCLES+3.
- Throughput: one transfer per HOLD_CYCLES+3 cycles.
- Rejection: err is high in cycle 1. req_ready stays 1, so a new request may be accepted at the edge ending cycle 1.
- err and done are never high in the same cycle.
- clear low mid-transfer: at that edge all outputs return to reset values. A pending dst_load is suppressed and no done is produced.
- clear low overrides req_valid on the same edge.

## Test plan
- **Basic transfer, HOLD_CYCLES=1:** src bit 20 (PC), dst bit 3 (R3), req_valid for 1 cycle.
  - Cycle 1: select=20.
  - Cycle 2: select=20, dst_load=24'h000008.
  - Cycle 3: done=1, select=31.
  - Cycle 4: req_ready=1.
- **HOLD_CYCLES=3:** src bit 21 (MDR), dst 24'h000003 (R0 and R1).
  - select=21 for cycles 1-4.
  - dst_load=24'h000003 only in cycle 4.
  - done in cycle 5.
- **Rejection:**
  - src 24'h000005 → err=1 in cycle 1, select stays 31, dst_load stays 0.
  - src 24'h0 → same response.
  - src valid, dst 24'h0 → same response.
  - A valid request at cycle 1 is then accepted normally.
- **Busy ignore:** toggle req_valid with a different src during DRIVE/LOAD/DONE. Only the first transfer's code and dst appear. No second done occurs until a request is made in IDLE.
- **Reset mid-operation:** drive clear low in the DRIVE cycle → dst_load never asserts, done never asserts, select=31, req_ready=1 on the following cycle.
- **Encode sweep:** for i=0..23, src=1<<i → select=i during DRIVE.
